// File: rtl/rtc_bus_pkg.sv
// Shared types, default timing and dwell helper for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

    localparam int unsigned T_PULSE_DEF = 10;
    localparam int unsigned T_GAP_DEF   = 5;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned BUS_W       = 8;

    typedef enum logic [3:0] {
        IDLE,
        A_SET,
        A_PULSE,
        A_HOLD,
        GAP,
        D_SET,
        D_PULSE,
        D_HOLD,
        DONE
    } estado_e;

    typedef struct packed {
        logic             rw;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } rtc_req_t;

    // Counter preload for a state: its dwell in cycles minus one.
    function automatic logic [CNT_W-1:0] dwell_m1(estado_e s, int unsigned tp, int unsigned tg);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            A_PULSE, D_PULSE: v = CNT_W'(tp - 1);
            GAP:              v = CNT_W'(tg - 1);
            default:          v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase timer: loadable 8-bit down-counter that parks at zero and flags it.
module temporizador_fase
    import rtc_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_c_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// Sequencer for a multiplexed address/data RTC bus: address phase, gap, data phase,
// with active-low strobes and a registered tri-state driver.
module secuenciador_bus_rtc
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req,
    input  logic             rw,
    input  logic [BUS_W-1:0] addr,
    input  logic [BUS_W-1:0] wdata,
    output logic             ready,
    output logic             done,
    output logic [BUS_W-1:0] rdata,
    output logic             CSO,
    output logic             ADO,
    output logic             WRO,
    output logic             RDO,
    inout  wire  [BUS_W-1:0] Bus_Dato_Dir
);

    estado_e          state_q, state_d;
    rtc_req_t         txn_q, txn_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             cso_q, ado_q, wro_q, rdo_q, oe_q, ready_q, done_q;
    logic             cso_d, ado_d, wro_d, rdo_d, oe_d, ready_d, done_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic             zero_c;

    temporizador_fase u_timer (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .load_i     (load_c),
        .load_val_i (load_val_c),
        .zero_c_o   (zero_c)
    );

    // Next state, request latch, read capture and next-cycle pin values.
    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        rdata_d    = rdata_q;
        cso_d      = 1'b1;
        ado_d      = 1'b1;
        wro_d      = 1'b1;
        rdo_d      = 1'b1;
        oe_d       = 1'b0;
        bus_d      = '0;
        ready_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = A_SET;
                    txn_d.rw    = rw;
                    txn_d.addr  = addr;
                    txn_d.wdata = wdata;
                end
            end
            A_SET:   if (zero_c) state_d = A_PULSE;
            A_PULSE: if (zero_c) state_d = A_HOLD;
            A_HOLD:  if (zero_c) state_d = GAP;
            GAP:     if (zero_c) state_d = D_SET;
            D_SET:   if (zero_c) state_d = D_PULSE;
            D_PULSE: begin
                if (zero_c) begin
                    state_d = D_HOLD;
                    if (txn_q.rw) begin
                        rdata_d = Bus_Dato_Dir;
                    end
                end
            end
            D_HOLD:  if (zero_c) state_d = DONE;
            DONE:    if (zero_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        load_c     = (state_d != state_q);
        load_val_c = dwell_m1(state_d, T_PULSE, T_GAP);

        // Pins are decoded from the state being entered so they register with it.
        case (state_d)
            IDLE: ready_d = 1'b1;
            A_SET, A_HOLD, A_PULSE: begin
                cso_d = 1'b0;
                ado_d = 1'b0;
                oe_d  = 1'b1;
                bus_d = txn_d.addr;
                wro_d = (state_d != A_PULSE);
            end
            D_SET, D_HOLD, D_PULSE: begin
                cso_d = 1'b0;
                oe_d  = ~txn_d.rw;
                bus_d = txn_d.wdata;
                if (state_d == D_PULSE) begin
                    wro_d = txn_d.rw;
                    rdo_d = ~txn_d.rw;
                end
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            txn_q   <= '0;
            rdata_q <= '0;
            cso_q   <= 1'b1;
            ado_q   <= 1'b1;
            wro_q   <= 1'b1;
            rdo_q   <= 1'b1;
            oe_q    <= 1'b0;
            bus_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            rdata_q <= rdata_d;
            cso_q   <= cso_d;
            ado_q   <= ado_d;
            wro_q   <= wro_d;
            rdo_q   <= rdo_d;
            oe_q    <= oe_d;
            bus_q   <= bus_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign CSO          = cso_q;
    assign ADO          = ado_q;
    assign WRO          = wro_q;
    assign RDO          = rdo_q;
    assign Bus_Dato_Dir = oe_q ? bus_q : {BUS_W{1'bz}};

endmodule
